// File: rtl/detector_feed_controller.sv
// Bit feeder for the 1100111 detector: a debounced manual key or timed autoplay of a latched pattern, plus a match counter.
// Optional macro FEED_MATCH_STOP_EN: a sampled match during autoplay ends playback with pos left after the matching bit.
module detector_feed_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned STEP_CYCLES     = 25000000,
    parameter int unsigned PAT_LEN         = 16
) (
    input  logic        clk,
    input  logic        reset_key,
    input  logic        key_step,
    input  logic        sw_bit,
    input  logic        auto_start,
    input  logic [15:0] pattern,
    input  logic        det_match,
    output logic        bit_valid,
    output logic        bit_data,
    output logic        busy,
    output logic [3:0]  pos,
    output logic [7:0]  match_count
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ST_W = $clog2(STEP_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST  = ST_W'(STEP_CYCLES - 1);
    localparam logic [3:0]      POS_LAST = 4'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HOLD     = 2'd2,
        S_AUTO     = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic key_meta, key_sync, sw_meta, sw_sync, auto_meta, auto_sync, auto_prev;
    logic auto_rise;

    logic [DB_W-1:0] db_cnt, db_cnt_nxt;
    logic [ST_W-1:0] step_cnt, step_cnt_nxt;
    logic [15:0]     pat_q, pat_nxt;
    logic            done_q, done_nxt;
    logic            valid_nxt, data_nxt;
    logic [3:0]      pos_nxt;
    logic [3:0]      bit_idx;
    logic            pend_q;
    logic            match_hit;

    assign auto_rise = auto_sync & ~auto_prev;
    assign match_hit = pend_q & det_match;
    assign bit_idx   = POS_LAST - pos;

    // Two-flop synchronizers and auto_start edge history
    always_ff @(posedge clk or posedge reset_key) begin
        if (reset_key) begin
            key_meta  <= 1'b0;
            key_sync  <= 1'b0;
            sw_meta   <= 1'b0;
            sw_sync   <= 1'b0;
            auto_meta <= 1'b0;
            auto_sync <= 1'b0;
            auto_prev <= 1'b0;
        end else begin
            key_meta  <= key_step;
            key_sync  <= key_meta;
            sw_meta   <= sw_bit;
            sw_sync   <= sw_meta;
            auto_meta <= auto_start;
            auto_sync <= auto_meta;
            auto_prev <= auto_sync;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset_key) begin
        if (reset_key) begin
            state     <= S_IDLE;
            db_cnt    <= '0;
            step_cnt  <= '0;
            pat_q     <= '0;
            done_q    <= 1'b0;
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
            busy      <= 1'b0;
            pos       <= '0;
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            step_cnt  <= step_cnt_nxt;
            pat_q     <= pat_nxt;
            done_q    <= done_nxt;
            bit_valid <= valid_nxt;
            bit_data  <= data_nxt;
            busy      <= (state_nxt != S_IDLE);
            pos       <= pos_nxt;
        end
    end

    // Next-state logic; the !bit_valid guards keep strobes from landing on adjacent cycles
    always_comb begin
        state_nxt    = state;
        db_cnt_nxt   = db_cnt;
        step_cnt_nxt = step_cnt;
        pat_nxt      = pat_q;
        done_nxt     = done_q;
        valid_nxt    = 1'b0;
        data_nxt     = bit_data;
        pos_nxt      = pos;

        case (state)
            S_IDLE: begin
                if (auto_rise) begin
                    state_nxt    = S_AUTO;
                    pat_nxt      = pattern;
                    pos_nxt      = '0;
                    step_cnt_nxt = '0;
                    done_nxt     = 1'b0;
                end else if (key_sync) begin
                    state_nxt  = S_DEBOUNCE;
                    db_cnt_nxt = '0;
                end
            end

            S_DEBOUNCE: begin
                if (!key_sync) begin
                    state_nxt = S_IDLE;
                end else if (db_cnt == DB_LAST) begin
                    if (!bit_valid) begin
                        valid_nxt  = 1'b1;
                        data_nxt   = sw_sync;
                        state_nxt  = S_HOLD;
                        db_cnt_nxt = '0;
                    end
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end

            S_HOLD: begin
                if (key_sync) begin
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = S_IDLE;
                    db_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end

            S_AUTO: begin
                if (done_q) begin
                    state_nxt    = S_IDLE;
                    pos_nxt      = '0;
                    done_nxt     = 1'b0;
                    step_cnt_nxt = '0;
`ifdef FEED_MATCH_STOP_EN
                end else if (match_hit) begin
                    state_nxt    = S_IDLE;
                    step_cnt_nxt = '0;
`endif
                end else if (step_cnt == ST_LAST) begin
                    if (!bit_valid) begin
                        valid_nxt    = 1'b1;
                        data_nxt     = pat_q[bit_idx];
                        step_cnt_nxt = '0;
                        if (pos == POS_LAST) begin
                            done_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos + 4'd1;
                        end
                    end
                end else begin
                    step_cnt_nxt = step_cnt + ST_W'(1);
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    // Match sampling one cycle after each strobe, saturating at 255
    always_ff @(posedge clk or posedge reset_key) begin
        if (reset_key) begin
            pend_q      <= 1'b0;
            match_count <= '0;
        end else begin
            pend_q <= bit_valid;
            if (match_hit && (match_count != 8'hFF)) begin
                match_count <= match_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_detector_feed_controller.sv
// Directed bench for detector_feed_controller with a small 1100111 detector model on det_match.
`timescale 1ns/1ps
module tb_detector_feed_controller;

    logic        clk;
    logic        reset_key;
    logic        key_step;
    logic        sw_bit;
    logic        auto_start;
    logic [15:0] pattern;
    logic        det_match;
    logic        bit_valid;
    logic        bit_data;
    logic        busy;
    logic [3:0]  pos;
    logic [7:0]  match_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int sq_cyc[$];
    int sq_bit[$];

    logic       force_match;
    logic [5:0] det_sh;
    logic       det_model;

    detector_feed_controller #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (3),
        .PAT_LEN        (16)
    ) dut (
        .clk        (clk),
        .reset_key  (reset_key),
        .key_step   (key_step),
        .sw_bit     (sw_bit),
        .auto_start (auto_start),
        .pattern    (pattern),
        .det_match  (det_match),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .busy       (busy),
        .pos        (pos),
        .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Detector model: det_match valid the cycle after a strobe completes 1100111
    always @(posedge clk or posedge reset_key) begin
        if (reset_key) begin
            det_sh    <= '0;
            det_model <= 1'b0;
        end else if (bit_valid) begin
            det_sh    <= {det_sh[4:0], bit_data};
            det_model <= ({det_sh, bit_data} == 7'b1100111);
        end else begin
            det_model <= 1'b0;
        end
    end
    assign det_match = force_match | det_model;

    always @(negedge clk) begin
        if (!reset_key && bit_valid === 1'b1) begin
            sq_cyc.push_back(cyc);
            sq_bit.push_back(int'(bit_data));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_key   = 1'b1;
        key_step    = 1'b0;
        sw_bit      = 1'b0;
        auto_start  = 1'b0;
        force_match = 1'b0;
        repeat (2) @(negedge clk);
        reset_key = 1'b0;
        @(negedge clk);
        sq_cyc.delete();
        sq_bit.delete();
    endtask

    task automatic test_reset();
        reset_key   = 1'b1;
        key_step    = 1'b0;
        sw_bit      = 1'b0;
        auto_start  = 1'b0;
        pattern     = '0;
        force_match = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bit_valid, bit_data, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000", {bit_valid, bit_data, busy});
        end
        n_cmp++;
        if (pos !== 4'd0) begin
            n_err++;
            $display("FAIL reset_pos: got %0d expected 0", pos);
        end
        n_cmp++;
        if (match_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d expected 0", match_count);
        end
        reset_key = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bit_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got %b expected 00", {bit_valid, busy});
        end
    endtask

    task automatic test_manual();
        int n;
        do_reset();
        n        = cyc;
        sw_bit   = 1'b1;
        key_step = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL manual_busy_hold: got %b expected 1", busy);
        end
        key_step = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (sq_cyc.size() !== 1) begin
            n_err++;
            $display("FAIL manual_strobes: got %0d expected 1", sq_cyc.size());
        end
        n_cmp++;
        if (((sq_cyc.size() > 0) ? sq_cyc[0] : -1) !== n + 7) begin
            n_err++;
            $display("FAIL manual_latency: got %0d expected %0d", (sq_cyc.size() > 0) ? sq_cyc[0] : -1, n + 7);
        end
        n_cmp++;
        if (((sq_bit.size() > 0) ? sq_bit[0] : -1) !== 1) begin
            n_err++;
            $display("FAIL manual_bit: got %0d expected 1", (sq_bit.size() > 0) ? sq_bit[0] : -1);
        end
        n_cmp++;
        if ({busy, bit_data} !== 2'b01) begin
            n_err++;
            $display("FAIL manual_end: busy,bit_data got %b expected 01", {busy, bit_data});
        end
    endtask

    task automatic test_bounce();
        do_reset();
        sw_bit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_step = 1'b1;
            repeat (2) @(negedge clk);
            key_step = 1'b0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (sq_cyc.size() !== 0) begin
            n_err++;
            $display("FAIL bounce_strobes: got %0d expected 0", sq_cyc.size());
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_autoplay();
        int          n;
        int          exp_n;
        bit          ok;
        bit          spacing_ok;
        logic [15:0] word;
        logic [15:0] exp_word;
        logic [3:0]  exp_pos;
        logic        exp_last;
`ifdef FEED_MATCH_STOP_EN
        exp_n   = 10;
        exp_pos = 4'd10;
`else
        exp_n   = 16;
        exp_pos = 4'd0;
`endif
        do_reset();
        pattern    = 16'b0001_1001_1100_0000;
        exp_word   = pattern >> (16 - exp_n);
        exp_last   = pattern[16 - exp_n];
        n          = cyc;
        auto_start = 1'b1;
        repeat (2) @(negedge clk);
        auto_start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL auto_busy_start: got %b expected 1", busy);
        end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL auto_end: busy still %b expected 0 within budget", busy);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sq_cyc.size() !== exp_n) begin
            n_err++;
            $display("FAIL auto_strobes: got %0d expected %0d", sq_cyc.size(), exp_n);
        end
        n_cmp++;
        if (((sq_cyc.size() > 0) ? sq_cyc[0] : -1) !== n + 6) begin
            n_err++;
            $display("FAIL auto_latency: got %0d expected %0d", (sq_cyc.size() > 0) ? sq_cyc[0] : -1, n + 6);
        end
        word       = '0;
        spacing_ok = 1'b1;
        for (int i = 0; i < sq_bit.size(); i++) begin
            word = {word[14:0], sq_bit[i][0]};
            if (i > 0 && (sq_cyc[i] - sq_cyc[i-1]) != 3) spacing_ok = 1'b0;
        end
        n_cmp++;
        if (word !== exp_word) begin
            n_err++;
            $display("FAIL auto_bits: got %h expected %h", word, exp_word);
        end
        n_cmp++;
        if (spacing_ok !== 1'b1) begin
            n_err++;
            $display("FAIL auto_spacing: got irregular spacing expected 3 cycles");
        end
        n_cmp++;
        if (match_count !== 8'd1) begin
            n_err++;
            $display("FAIL auto_match_count: got %0d expected 1", match_count);
        end
        n_cmp++;
        if ({pos, bit_data} !== {exp_pos, exp_last}) begin
            n_err++;
            $display("FAIL auto_pos_data: got %0d/%b expected %0d/%b", pos, bit_data, exp_pos, exp_last);
        end
    endtask

    task automatic test_saturation();
        int  first;
        bit  ok;
        int  exp_first;
`ifdef FEED_MATCH_STOP_EN
        exp_first = 1;
`else
        exp_first = 16;
`endif
        do_reset();
        pattern     = 16'h5A5A;
        force_match = 1'b1;
        first       = -1;
        ok          = 1'b1;
        for (int p = 0; p < 400 && sq_cyc.size() < 300 && ok; p++) begin
            auto_start = 1'b1;
            repeat (2) @(negedge clk);
            auto_start = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (i > 1 && busy === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(negedge clk);
            if (p == 0) first = int'(match_count);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL sat_playback: busy got %b expected 0 within budget", busy);
        end
        n_cmp++;
        if (first !== exp_first) begin
            n_err++;
            $display("FAIL sat_first_playback: got %0d expected %0d", first, exp_first);
        end
        n_cmp++;
        if (match_count !== 8'd255) begin
            n_err++;
            $display("FAIL sat_count: got %0d expected 255 after %0d strobes", match_count, sq_cyc.size());
        end
        force_match = 1'b0;
    endtask

    task automatic test_simultaneous();
        int          n;
        bit          ok;
        logic [15:0] word;
        do_reset();
        pattern    = 16'hA5C3;
        sw_bit     = 1'b1;
        n          = cyc;
        key_step   = 1'b1;
        auto_start = 1'b1;
        repeat (2) @(negedge clk);
        auto_start = 1'b0;
        @(negedge clk);
        key_step = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL simul_end: busy got %b expected 0 within budget", busy);
        end
        n_cmp++;
        if (((sq_cyc.size() > 0) ? sq_cyc[0] : -1) !== n + 6) begin
            n_err++;
            $display("FAIL simul_first: got %0d expected %0d", (sq_cyc.size() > 0) ? sq_cyc[0] : -1, n + 6);
        end
        word = '0;
        for (int i = 0; i < sq_bit.size(); i++) word = {word[14:0], sq_bit[i][0]};
        n_cmp++;
        if ({16'(sq_bit.size()), word} !== {16'd16, 16'hA5C3}) begin
            n_err++;
            $display("FAIL simul_bits: got %0d strobes word %h expected 16 strobes word a5c3", sq_bit.size(), word);
        end
    endtask

    task automatic test_reset_mid_auto();
        bit ok;
        do_reset();
        pattern    = 16'b0001_1001_1100_0000;
        auto_start = 1'b1;
        repeat (2) @(negedge clk);
        auto_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pos === 4'd5) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rst_reach_pos5: pos got %0d expected 5", pos);
        end
        reset_key = 1'b1;
        #1;
        n_cmp++;
        if ({bit_valid, bit_data, busy, pos, match_count} !== 15'd0) begin
            n_err++;
            $display("FAIL rst_async: got v%b d%b b%b p%0d c%0d expected all 0",
                     bit_valid, bit_data, busy, pos, match_count);
        end
        repeat (2) @(negedge clk);
        reset_key = 1'b0;
        sq_cyc.delete();
        sq_bit.delete();
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({32'(sq_cyc.size()), busy} !== {32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_no_strobe: got %0d strobes busy %b expected 0/0", sq_cyc.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_bounce();
        test_autoplay();
        test_saturation();
        test_simultaneous();
        test_reset_mid_auto();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
